// File: rtl/gemm_tile_controller_if.sv
// ----------------------------------------------------------------------------
// gemm_tile_controller_if
// Operand-beat and C-tile result handshake bundle of the GEMM tile controller.
// Signal suffixes are from the controller's point of view.
//
//   in_valid_i      upstream operand beat available
//   in_ready_o      controller can take an operand beat
//   init_save_o     current beat is the first K block of a C tile
//   result_valid_o  a finished C tile is pending
//   result_ready_i  downstream accepts the pending C tile
//   M_write_o       M index of the pending C tile
//   N_write_o       N index of the pending C tile
//
// master: controller side.  slave: environment side.
// ----------------------------------------------------------------------------
interface gemm_tile_controller_if #(
  parameter int unsigned AddrWidth = 16
) ();

  logic                 in_valid_i;
  logic                 in_ready_o;
  logic                 init_save_o;
  logic                 result_valid_o;
  logic                 result_ready_i;
  logic [AddrWidth-1:0] M_write_o;
  logic [AddrWidth-1:0] N_write_o;

  modport master (
    input  in_valid_i,
    input  result_ready_i,
    output in_ready_o,
    output init_save_o,
    output result_valid_o,
    output M_write_o,
    output N_write_o
  );

  modport slave (
    output in_valid_i,
    output result_ready_i,
    input  in_ready_o,
    input  init_save_o,
    input  result_valid_o,
    input  M_write_o,
    input  N_write_o
  );

endinterface

// File: rtl/gemm_tile_controller.sv
// ----------------------------------------------------------------------------
// gemm_tile_controller
// Walks a GEMM job of M x N C tiles, each accumulated over K operand beats.
// K is always the inner loop; order_i selects whether M or N is outermost.
// A C tile is reported on the result handshake the cycle after its last K
// beat, and operand beats are throttled while a reported tile is unaccepted.
//
// Ports
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   start_i                       launch a job (only looked at in IDLE)
//   abort_i                       terminate the running job with error
//   order_i                       0: M/N/K loop nest, 1: N/M/K loop nest
//   M_size_i, K_size_i, N_size_i  block counts, captured at start
//   bus (master)                  operand beat and C tile result handshakes
//   M_count_o, K_count_o, N_count_o  current block indices
//   busy_o, done_o, error_o       status (done/error pulse in FINISH)
//   cycle_cnt_o, stall_cnt_o      saturating perf counters (optional)
//
// Optional feature: define GEMM_CTRL_PERF_EN to add the performance counters.
// ----------------------------------------------------------------------------
module gemm_tile_controller #(
  parameter int unsigned AddrWidth = 16,
  parameter int unsigned PerfWidth = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   start_i,
  input  logic                   abort_i,
  input  logic                   order_i,
  input  logic [AddrWidth-1:0]   M_size_i,
  input  logic [AddrWidth-1:0]   K_size_i,
  input  logic [AddrWidth-1:0]   N_size_i,
  gemm_tile_controller_if.master bus,
  output logic [AddrWidth-1:0]   M_count_o,
  output logic [AddrWidth-1:0]   K_count_o,
  output logic [AddrWidth-1:0]   N_count_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   error_o
`ifdef GEMM_CTRL_PERF_EN
  ,
  output logic [PerfWidth-1:0]   cycle_cnt_o,
  output logic [PerfWidth-1:0]   stall_cnt_o
`endif
);

  // Reject degenerate widths at elaboration.
  if (AddrWidth == 0 || PerfWidth == 0) begin : g_bad_params
    $error("gemm_tile_controller: AddrWidth and PerfWidth must be non-zero");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY   = 2'd1,
    DRAIN  = 2'd2,
    FINISH = 2'd3
  } state_e;

  state_e state_q, state_d;

  logic [AddrWidth-1:0] m_size_q, m_size_d;
  logic [AddrWidth-1:0] k_size_q, k_size_d;
  logic [AddrWidth-1:0] n_size_q, n_size_d;
  logic [AddrWidth-1:0] m_cnt_q, m_cnt_d;
  logic [AddrWidth-1:0] k_cnt_q, k_cnt_d;
  logic [AddrWidth-1:0] n_cnt_q, n_cnt_d;
  logic [AddrWidth-1:0] m_wr_q, m_wr_d;
  logic [AddrWidth-1:0] n_wr_q, n_wr_d;
  logic                 order_q, order_d;
  logic                 err_q, err_d;
  logic                 res_valid_q, res_valid_d;
  logic                 done_q, done_d;
  logic                 busy_q, busy_d;
  logic                 error_q, error_d;

  logic in_ready;
  logic beat;
  logic adv;
  logic start_acc;
  logic size_zero;
  logic active_abort;
  logic res_accept;
  logic k_last, m_last, n_last;
  logic m_step, n_step;
  logic job_last;

  // Operand beats stall while a reported tile is still waiting downstream.
  assign in_ready     = (state_q == BUSY) && !(res_valid_q && !bus.result_ready_i);
  assign beat         = bus.in_valid_i && in_ready;
  // Abort wins over a simultaneous beat: the beat does not advance the walk.
  assign adv          = beat && !abort_i;
  assign start_acc    = (state_q == IDLE) && start_i;
  assign size_zero    = (M_size_i == '0) || (K_size_i == '0) || (N_size_i == '0);
  assign active_abort = abort_i && ((state_q == BUSY) || (state_q == DRAIN));
  assign res_accept   = res_valid_q && bus.result_ready_i;

  // Sizes are non-zero while walking, so size-1 never underflows in use.
  assign k_last = (k_cnt_q == k_size_q - AddrWidth'(1));
  assign m_last = (m_cnt_q == m_size_q - AddrWidth'(1));
  assign n_last = (n_cnt_q == n_size_q - AddrWidth'(1));

  // K wrap carries into the middle loop; middle wrap carries into the outer.
  assign m_step   = order_q ? k_last : (k_last && n_last);
  assign n_step   = order_q ? (k_last && m_last) : k_last;
  assign job_last = k_last && m_last && n_last;

  // Next state and registered status outputs.
  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    busy_d  = 1'b0;
    error_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = size_zero ? FINISH : BUSY;
        end
      end
      BUSY: begin
        if (abort_i) begin
          state_d = FINISH;
        end else if (adv && job_last) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (abort_i || res_accept) begin
          state_d = FINISH;
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    done_d  = (state_d == FINISH);
    busy_d  = (state_d != IDLE);
    error_d = (state_d == FINISH) && err_d;
  end

  // Loop counters, latched job parameters and the pending result.
  always_comb begin
    m_size_d    = m_size_q;
    k_size_d    = k_size_q;
    n_size_d    = n_size_q;
    order_d     = order_q;
    m_cnt_d     = m_cnt_q;
    k_cnt_d     = k_cnt_q;
    n_cnt_d     = n_cnt_q;
    m_wr_d      = m_wr_q;
    n_wr_d      = n_wr_q;
    err_d       = err_q;
    res_valid_d = res_valid_q;

    if (start_acc) begin
      m_size_d = M_size_i;
      k_size_d = K_size_i;
      n_size_d = N_size_i;
      order_d  = order_i;
      m_cnt_d  = '0;
      k_cnt_d  = '0;
      n_cnt_d  = '0;
      err_d    = size_zero;
    end

    if (state_q == FINISH) begin
      m_cnt_d = '0;
      k_cnt_d = '0;
      n_cnt_d = '0;
    end

    if (res_accept) begin
      res_valid_d = 1'b0;
    end

    if (adv) begin
      k_cnt_d = k_last ? '0 : k_cnt_q + AddrWidth'(1);
      if (m_step) begin
        m_cnt_d = m_last ? '0 : m_cnt_q + AddrWidth'(1);
      end
      if (n_step) begin
        n_cnt_d = n_last ? '0 : n_cnt_q + AddrWidth'(1);
      end
      // A tile completes on its last K beat; report the pre-beat indices.
      if (k_last) begin
        res_valid_d = 1'b1;
        m_wr_d      = m_cnt_q;
        n_wr_d      = n_cnt_q;
      end
    end

    if (active_abort) begin
      res_valid_d = 1'b0;
      err_d       = 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath and status registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      m_size_q    <= '0;
      k_size_q    <= '0;
      n_size_q    <= '0;
      order_q     <= 1'b0;
      m_cnt_q     <= '0;
      k_cnt_q     <= '0;
      n_cnt_q     <= '0;
      m_wr_q      <= '0;
      n_wr_q      <= '0;
      err_q       <= 1'b0;
      res_valid_q <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      m_size_q    <= m_size_d;
      k_size_q    <= k_size_d;
      n_size_q    <= n_size_d;
      order_q     <= order_d;
      m_cnt_q     <= m_cnt_d;
      k_cnt_q     <= k_cnt_d;
      n_cnt_q     <= n_cnt_d;
      m_wr_q      <= m_wr_d;
      n_wr_q      <= n_wr_d;
      err_q       <= err_d;
      res_valid_q <= res_valid_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      error_q     <= error_d;
    end
  end

  assign bus.in_ready_o     = in_ready;
  assign bus.init_save_o    = beat && (k_cnt_q == '0);
  assign bus.result_valid_o = res_valid_q;
  assign bus.M_write_o      = m_wr_q;
  assign bus.N_write_o      = n_wr_q;

  assign M_count_o = m_cnt_q;
  assign K_count_o = k_cnt_q;
  assign N_count_o = n_cnt_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign error_o   = error_q;

`ifdef GEMM_CTRL_PERF_EN
  logic [PerfWidth-1:0] cycle_cnt_q, cycle_cnt_d;
  logic [PerfWidth-1:0] stall_cnt_q, stall_cnt_d;
  logic                 perf_active;
  logic                 perf_stall;

  assign perf_active = (state_q == BUSY) || (state_q == DRAIN);
  assign perf_stall  = (state_q == BUSY) && bus.in_valid_i && !in_ready;

  // Saturating job counters; cleared by a new job, frozen in IDLE.
  always_comb begin
    cycle_cnt_d = cycle_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (start_acc) begin
      cycle_cnt_d = '0;
      stall_cnt_d = '0;
    end else begin
      if (perf_active && !(&cycle_cnt_q)) begin
        cycle_cnt_d = cycle_cnt_q + PerfWidth'(1);
      end
      if (perf_stall && !(&stall_cnt_q)) begin
        stall_cnt_d = stall_cnt_q + PerfWidth'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cycle_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      cycle_cnt_q <= cycle_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign cycle_cnt_o = cycle_cnt_q;
  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_gemm_tile_controller.sv
// ----------------------------------------------------------------------------
// tb_gemm_tile_controller
// Directed jobs against gemm_tile_controller. A cycle-level reference built
// on a flat beat index (counts derived by div/mod) checks every output on
// every falling edge; logged handshake events are pinned against hand values.
// ----------------------------------------------------------------------------
module tb_gemm_tile_controller;

  localparam int unsigned AW = 16;
  localparam int unsigned PW = 32;

  localparam int P_IDLE = 0;
  localparam int P_BUSY = 1;
  localparam int P_DRAIN = 2;
  localparam int P_FIN = 3;

  logic          clk_i   = 1'b0;
  logic          rst_ni  = 1'b0;
  logic          start_i = 1'b0;
  logic          abort_i = 1'b0;
  logic          order_i = 1'b0;
  logic [AW-1:0] M_size_i = '0;
  logic [AW-1:0] K_size_i = '0;
  logic [AW-1:0] N_size_i = '0;
  logic [AW-1:0] M_count_o, K_count_o, N_count_o;
  logic          busy_o, done_o, error_o;
`ifdef GEMM_CTRL_PERF_EN
  logic [PW-1:0] cycle_cnt_o, stall_cnt_o;
`endif

  gemm_tile_controller_if #(.AddrWidth(AW)) bus ();

  gemm_tile_controller #(.AddrWidth(AW), .PerfWidth(PW)) dut (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .start_i   (start_i),
    .abort_i   (abort_i),
    .order_i   (order_i),
    .M_size_i  (M_size_i),
    .K_size_i  (K_size_i),
    .N_size_i  (N_size_i),
    .bus       (bus),
    .M_count_o (M_count_o),
    .K_count_o (K_count_o),
    .N_count_o (N_count_o),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .error_o   (error_o)
`ifdef GEMM_CTRL_PERF_EN
    ,
    .cycle_cnt_o (cycle_cnt_o),
    .stall_cnt_o (stall_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;

  // Reference job state.
  int     ph   = P_IDLE;
  longint ms   = 0, ks = 0, ns = 0;
  bit     mo   = 1'b0;
  bit     live = 1'b0;
  bit     merr = 1'b0;
  bit     mrv  = 1'b0;
  longint mb   = 0;
  longint mwm  = 0, mwn = 0;
  longint pcyc = 0, pstl = 0;

  // Event logs (written only by the compare process).
  int unsigned wr_log[$];
  int unsigned rvb_log[$];
  int unsigned init_log[$];
  int unsigned beats_n = 0;
  int          cyc = 0;
  int          last_beat_cyc = 0;
  int          done_cyc = 0;
  int unsigned done_n = 0;

  int unsigned exp_wr_mn[4] = '{32'h0000_0000, 32'h0000_0001, 32'h0001_0000, 32'h0001_0001};
  int unsigned exp_wr_nm[4] = '{32'h0000_0000, 32'h0001_0000, 32'h0000_0001, 32'h0001_0001};
  int unsigned exp_rvb[4]   = '{3, 6, 9, 12};
  int unsigned exp_init[4]  = '{1, 4, 7, 10};

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
  endtask

  // Block indices of flat beat b under the latched job.
  task automatic idx(input longint b, output longint m, output longint k, output longint n);
    longint mid_sz, out_sz, mid, outer;
    if (!live) begin
      m = 0; k = 0; n = 0;
    end else begin
      mid_sz = mo ? ms : ns;
      out_sz = mo ? ns : ms;
      k      = b % ks;
      mid    = (b / ks) % mid_sz;
      outer  = (b / (ks * mid_sz)) % out_sz;
      m      = mo ? mid : outer;
      n      = mo ? outer : mid;
    end
  endtask

  always @(negedge clk_i) begin : cmp
    longint cm, ck, cn;
    bit     e_rdy, e_beat, e_init, n_rv;
    cyc++;
    if (!rst_ni) begin
      chk("rst_busy", 64'(busy_o), 64'd0);
      chk("rst_done", 64'(done_o), 64'd0);
      chk("rst_error", 64'(error_o), 64'd0);
      chk("rst_rvalid", 64'(bus.result_valid_o), 64'd0);
      chk("rst_ready", 64'(bus.in_ready_o), 64'd0);
      chk("rst_counts", 64'({M_count_o, K_count_o, N_count_o}), 64'd0);
      chk("rst_writes", 64'({bus.M_write_o, bus.N_write_o}), 64'd0);
`ifdef GEMM_CTRL_PERF_EN
      chk("rst_perf", 64'({cycle_cnt_o, stall_cnt_o}), 64'd0);
`endif
      ph = P_IDLE; live = 0; merr = 0; mrv = 0; mb = 0; mwm = 0; mwn = 0;
      ms = 0; ks = 0; ns = 0; mo = 0; pcyc = 0; pstl = 0;
    end else begin
      idx(mb, cm, ck, cn);
      e_rdy  = (ph == P_BUSY) && !(mrv && !bus.result_ready_i);
      e_beat = bus.in_valid_i && e_rdy;
      e_init = e_beat && (ck == 0);

      chk("busy", 64'(busy_o), 64'(ph != P_IDLE));
      chk("done", 64'(done_o), 64'(ph == P_FIN));
      chk("error", 64'(error_o), 64'(ph == P_FIN && merr));
      chk("rvalid", 64'(bus.result_valid_o), 64'(mrv));
      if (mrv) begin
        chk("m_write", 64'(bus.M_write_o), 64'(mwm));
        chk("n_write", 64'(bus.N_write_o), 64'(mwn));
      end
      chk("in_ready", 64'(bus.in_ready_o), 64'(e_rdy));
      chk("init_save", 64'(bus.init_save_o), 64'(e_init));
      chk("m_count", 64'(M_count_o), 64'(cm));
      chk("k_count", 64'(K_count_o), 64'(ck));
      chk("n_count", 64'(N_count_o), 64'(cn));
`ifdef GEMM_CTRL_PERF_EN
      chk("cycle_cnt", 64'(cycle_cnt_o), 64'(pcyc));
      chk("stall_cnt", 64'(stall_cnt_o), 64'(pstl));
`endif

      // Event logs from the DUT side.
      if (bus.result_valid_o) rvb_log.push_back(beats_n);
      if (bus.result_valid_o && bus.result_ready_i)
        wr_log.push_back({bus.M_write_o, bus.N_write_o});
      if (bus.in_valid_i && bus.in_ready_o) begin
        if (bus.init_save_o) init_log.push_back(beats_n + 1);
        beats_n++;
        last_beat_cyc = cyc;
      end
      if (done_o) begin
        done_n++;
        done_cyc = cyc;
      end

      // Reference update for the coming rising edge.
      if (ph == P_BUSY || ph == P_DRAIN) begin
        pcyc = pcyc + 1;
        if (ph == P_BUSY && bus.in_valid_i && !e_rdy) pstl = pstl + 1;
      end
      case (ph)
        P_IDLE: begin
          if (start_i) begin
            ms = longint'(M_size_i); ks = longint'(K_size_i); ns = longint'(N_size_i);
            mo = order_i; mb = 0; mrv = 0;
            merr = (ms == 0) || (ks == 0) || (ns == 0);
            live = !merr;
            ph = merr ? P_FIN : P_BUSY;
            pcyc = 0; pstl = 0;
          end
        end
        P_BUSY: begin
          if (abort_i) begin
            mrv = 0; merr = 1; ph = P_FIN;
          end else begin
            n_rv = mrv && !bus.result_ready_i;
            if (e_beat) begin
              if (ck == ks - 1) begin
                n_rv = 1; mwm = cm; mwn = cn;
              end
              mb = mb + 1;
              if (mb == ms * ks * ns) ph = P_DRAIN;
            end
            mrv = n_rv;
          end
        end
        P_DRAIN: begin
          if (abort_i) begin
            mrv = 0; merr = 1; ph = P_FIN;
          end else if (mrv && bus.result_ready_i) begin
            mrv = 0; ph = P_FIN;
          end
        end
        default: begin
          ph = P_IDLE; live = 0; mb = 0;
        end
      endcase
    end
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic start_job(input int m, input int k, input int n, input bit ord);
    M_size_i = AW'(m);
    K_size_i = AW'(k);
    N_size_i = AW'(n);
    order_i  = ord;
    start_i  = 1'b1;
    step();
    start_i  = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int budget);
    int i = 0;
    while (!done_o && i < budget) begin
      step();
      i++;
    end
    chk(nm, 64'(done_o), 64'd1);
  endtask

  task automatic chk_seq4(input string nm, input int unsigned got[$], input int base,
                          input int unsigned off, input int unsigned e[4]);
    chk({nm, "_len"}, 64'(got.size() - base), 64'd4);
    for (int i = 0; i < 4; i++)
      if (base + i < got.size())
        chk($sformatf("%s_%0d", nm, i), 64'(got[base+i] - off), 64'(e[i]));
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : main
    int wb, rb, ib;
    int unsigned bb, dn;
    bus.in_valid_i     = 1'b0;
    bus.result_ready_i = 1'b0;
    repeat (2) step();
    chk("reset_busy", 64'(busy_o), 64'd0);
    chk("reset_wr", 64'({bus.M_write_o, bus.N_write_o}), 64'd0);
    rst_ni = 1'b1;
    step();

    // 2x3x2, order 0, free-flowing handshakes.
    wb = wr_log.size(); rb = rvb_log.size(); bb = beats_n;
    bus.in_valid_i = 1'b1; bus.result_ready_i = 1'b1;
    start_job(2, 3, 2, 1'b0);
    wait_done("A_done", 40);
    step();
    chk("A_beats", 64'(beats_n - bb), 64'd12);
    chk_seq4("A_wr", wr_log, wb, 0, exp_wr_mn);
    chk_seq4("A_rv_after", rvb_log, rb, bb, exp_rvb);
    chk("A_done_lat", 64'(done_cyc - last_beat_cyc), 64'd2);
    chk("A_idle", 64'(busy_o), 64'd0);

    // Same job, order 1.
    wb = wr_log.size(); ib = init_log.size(); bb = beats_n;
    start_job(2, 3, 2, 1'b1);
    wait_done("B_done", 40);
    step();
    chk_seq4("B_wr", wr_log, wb, 0, exp_wr_nm);
    chk_seq4("B_init", init_log, ib, bb, exp_init);

    // 1x1x2 with the first result held back for 5 cycles.
    bus.result_ready_i = 1'b0;
    start_job(1, 1, 2, 1'b0);
    step();
    chk("C_rv", 64'(bus.result_valid_o), 64'd1);
    chk("C_stall_rdy", 64'(bus.in_ready_o), 64'd0);
    repeat (4) step();
    chk("C_hold_rdy", 64'(bus.in_ready_o), 64'd0);
    chk("C_hold_wr", 64'({bus.M_write_o, bus.N_write_o}), 64'd0);
    bus.result_ready_i = 1'b1;
    wait_done("C_done", 20);
`ifdef GEMM_CTRL_PERF_EN
    chk("C_stall_cnt", 64'(stall_cnt_o), 64'd5);
    chk("C_cycle_cnt", 64'(cycle_cnt_o), 64'd8);
    step();
    step();
    chk("C_stall_hold", 64'(stall_cnt_o), 64'd5);
`else
    step();
`endif

    // Zero K size: immediate error completion.
    bb = beats_n;
    start_job(2, 0, 2, 1'b0);
    chk("D_done", 64'(done_o), 64'd1);
    chk("D_error", 64'(error_o), 64'd1);
    step();
    chk("D_idle", 64'(busy_o), 64'd0);
    chk("D_beats", 64'(beats_n - bb), 64'd0);

    // Abort during beat 5, then a clean restart.
    start_job(2, 3, 2, 1'b0);
    repeat (4) step();
    abort_i = 1'b1;
    step();
    abort_i = 1'b0;
    chk("E_rv", 64'(bus.result_valid_o), 64'd0);
    chk("E_done", 64'(done_o), 64'd1);
    chk("E_error", 64'(error_o), 64'd1);
    chk("E_counts", 64'({M_count_o, K_count_o, N_count_o}), {16'd0, 16'd0, 16'd1, 16'd1});
    step();
    chk("E_idle", 64'(busy_o), 64'd0);
    wb = wr_log.size();
    start_job(2, 3, 2, 1'b0);
    wait_done("E2_done", 40);
    chk("E2_error", 64'(error_o), 64'd0);
    step();
    chk_seq4("E2_wr", wr_log, wb, 0, exp_wr_mn);

    // Reset while DRAIN holds a pending result.
    bus.result_ready_i = 1'b0;
    start_job(1, 1, 1, 1'b0);
    step();
    chk("F_pend", 64'({busy_o, bus.result_valid_o}), 64'd3);
    rst_ni = 1'b0;
    #1;
    chk("F_rst_out", 64'({busy_o, done_o, error_o, bus.result_valid_o}), 64'd0);
    chk("F_rst_cnt", 64'({M_count_o, K_count_o, N_count_o}), 64'd0);
    step();
    rst_ni = 1'b1;
    dn = done_n;
    repeat (4) step();
    chk("F_no_done", 64'(done_n - dn), 64'd0);
    bus.result_ready_i = 1'b1;
    wb = wr_log.size();
    start_job(2, 3, 2, 1'b0);
    wait_done("F2_done", 40);
    step();
    chk_seq4("F2_wr", wr_log, wb, 0, exp_wr_mn);

    repeat (2) step();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
